rom_program_sequencer: RTL and testbench

- Fetch/issue controller that steps a combinational 8-bit-address ROM as program memory.
- Decodes variable-length instructions: ALU op, jump, halt, nop.
- Presents ALU opcode and operands to the 8-bit ALU through a valid/ready handshake.
- Sits between the ROM array and the ALU, replacing manual address driving.

---
 rtl/rom_program_sequencer.sv | 153 +++++++++++++++
 tb/tb_rom_program_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_program_sequencer.sv
// Fetch/issue controller: walks a combinational ROM as program memory, decodes
// ALU / JMP / HALT / NOP instructions and hands ALU ops over a valid/ready port.
module rom_program_sequencer #(
    parameter logic [7:0] START_ADDR = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       op_valid,
    input  logic       op_ready,
    output logic [2:0] opcode,
    output logic [7:0] operand_a,
    output logic [7:0] operand_b,
    output logic       busy,
    output logic       halted,
    output logic [7:0] issue_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_OP,
        S_FETCH_ARG1,
        S_FETCH_ARG2,
        S_ISSUE,
        S_HALTED
    } state_t;

    // Instruction class lives in opcode byte bits [7:6].
    typedef enum logic [1:0] {
        K_ALU  = 2'b00,
        K_JMP  = 2'b01,
        K_HALT = 2'b10,
        K_NOP  = 2'b11
    } kind_t;

    state_t     state, state_next;
    logic [7:0] pc, pc_next;
    kind_t      instr_kind, instr_kind_next;
    logic [2:0] instr_op, instr_op_next;
    logic [2:0] opcode_next;
    logic [7:0] operand_a_next, operand_b_next;
    logic [7:0] issue_cnt_next;
    kind_t      fetched_kind;

    // Opcode byte bits [5:3] carry no meaning.
    logic unused_rom_bits;
    assign unused_rom_bits = ^rom_data[5:3];

    assign fetched_kind = kind_t'(rom_data[7:6]);

    // NOTE: every always_comb output gets a default before the case so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        instr_kind_next = instr_kind;
        instr_op_next   = instr_op;
        opcode_next     = opcode;
        operand_a_next  = operand_a;
        operand_b_next  = operand_b;
        issue_cnt_next  = issue_cnt;

        case (state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    pc_next        = START_ADDR;
                    issue_cnt_next = 8'd0;
                    state_next     = S_FETCH_OP;
                end
            end

            S_FETCH_OP: begin
                instr_kind_next = fetched_kind;
                instr_op_next   = rom_data[2:0];
                pc_next         = pc + 8'd1;
                case (fetched_kind)
                    K_ALU, K_JMP: state_next = S_FETCH_ARG1;
                    K_HALT:       state_next = S_HALTED;
                    default:      state_next = S_FETCH_OP;
                endcase
            end

            S_FETCH_ARG1: begin
                if (instr_kind == K_JMP) begin
                    pc_next    = rom_data;
                    state_next = S_FETCH_OP;
                end else begin
                    operand_a_next = rom_data;
                    pc_next        = pc + 8'd1;
                    state_next     = S_FETCH_ARG2;
                end
            end

            S_FETCH_ARG2: begin
                operand_b_next = rom_data;
                opcode_next    = instr_op;
                pc_next        = pc + 8'd1;
                state_next     = S_ISSUE;
            end

            S_ISSUE: begin
                if (op_ready) begin
                    issue_cnt_next = issue_cnt + 8'd1;
                    state_next     = S_FETCH_OP;
                end
            end

            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= START_ADDR;
            instr_kind <= K_NOP;
            instr_op   <= 3'd0;
            opcode     <= 3'd0;
            operand_a  <= 8'd0;
            operand_b  <= 8'd0;
            issue_cnt  <= 8'd0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            instr_kind <= instr_kind_next;
            instr_op   <= instr_op_next;
            opcode     <= opcode_next;
            operand_a  <= operand_a_next;
            operand_b  <= operand_b_next;
            issue_cnt  <= issue_cnt_next;
        end
    end

    assign rom_addr = pc;
    assign op_valid = (state == S_ISSUE);
    assign halted   = (state == S_HALTED);
    assign busy     = (state != S_IDLE) && (state != S_HALTED);

    // A stalled operation must keep its payload until the ALU takes it.
    op_payload_stable: assert property (
        @(posedge clk) disable iff (rst)
        (op_valid && !op_ready) |=> (op_valid && $stable({opcode, operand_a, operand_b}))
    );

    busy_halted_exclusive: assert property (
        @(posedge clk) disable iff (rst) !(busy && halted)
    );

endmodule

// File: tb/tb_rom_program_sequencer.sv
// Bench for rom_program_sequencer: directed timing scenarios plus random programs
// checked against an instruction-level interpreter of the ROM contents.
module tb_rom_program_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] opcode;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic       busy;
    logic       halted;
    logic [7:0] issue_cnt;

    logic [7:0] rom [256];

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    always_comb rom_data = rom[rom_addr];

    rom_program_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .opcode    (opcode),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .halted    (halted),
        .issue_cnt (issue_cnt)
    );

    task automatic fill_halts();
        for (int i = 0; i < 256; i++) rom[i] = 8'h80;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        start    = 1'b0;
        op_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Leaves the caller at the negedge just after the edge that sampled START.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [38:0] got, exp;
        do_reset();
        got = {op_valid, busy, halted, opcode, operand_a, operand_b, issue_cnt, rom_addr};
        exp = 39'd0;
        checks++;
        if (got !== exp) $display("FAIL reset_state got=%h exp=%h", got, exp);
        else passed++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({rom_addr, busy, op_valid} !== 10'd0)
                $display("FAIL idle_hold cyc=%0d addr=%h busy=%b valid=%b exp addr=00 busy=0 valid=0",
                         i, rom_addr, busy, op_valid);
            else passed++;
        end
    endtask

    task automatic test_alu_latency();
        logic [7:0] exp_addr [6] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h03, 8'h04};
        logic       exp_vld  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        fill_halts();
        rom[0] = 8'h03; rom[1] = 8'h12; rom[2] = 8'h34; rom[3] = 8'h80;
        do_reset();
        op_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({rom_addr, op_valid} !== {exp_addr[i], exp_vld[i]})
                $display("FAIL alu_latency cyc=%0d addr=%h valid=%b exp addr=%h valid=%b",
                         i, rom_addr, op_valid, exp_addr[i], exp_vld[i]);
            else passed++;
            if (i == 3) begin
                checks++;
                if ({opcode, operand_a, operand_b} !== {3'd3, 8'h12, 8'h34})
                    $display("FAIL alu_payload got=%0d/%h/%h exp=3/12/34", opcode, operand_a, operand_b);
                else passed++;
            end
            if (i < 5) @(negedge clk);
        end
        checks++;
        if ({halted, busy, issue_cnt} !== {1'b1, 1'b0, 8'd1})
            $display("FAIL alu_halt halted=%b busy=%b cnt=%0d exp 1/0/1", halted, busy, issue_cnt);
        else passed++;
    endtask

    task automatic test_restart_after_halt();
        pulse_start();
        checks++;
        if ({halted, busy, issue_cnt, rom_addr} !== {1'b0, 1'b1, 8'd0, 8'h00})
            $display("FAIL restart halted=%b busy=%b cnt=%0d addr=%h exp 0/1/0/00",
                     halted, busy, issue_cnt, rom_addr);
        else passed++;
        repeat (6) @(negedge clk);
        checks++;
        if ({halted, issue_cnt, rom_addr} !== {1'b1, 8'd1, 8'h04})
            $display("FAIL restart_end halted=%b cnt=%0d addr=%h exp 1/1/04", halted, issue_cnt, rom_addr);
        else passed++;
    endtask

    task automatic test_backpressure();
        op_ready = 1'b0;
        pulse_start();
        repeat (3) @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            checks++;
            if ({op_valid, opcode, operand_a, operand_b, issue_cnt} !== {1'b1, 3'd3, 8'h12, 8'h34, 8'd0})
                $display("FAIL stall_hold cyc=%0d valid=%b op=%0d a=%h b=%h cnt=%0d exp 1/3/12/34/0",
                         c, op_valid, opcode, operand_a, operand_b, issue_cnt);
            else passed++;
            if (c == 5) op_ready = 1'b1;
            @(negedge clk);
        end
        checks++;
        if ({op_valid, issue_cnt} !== {1'b0, 8'd1})
            $display("FAIL stall_accept valid=%b cnt=%0d exp 0/1", op_valid, issue_cnt);
        else passed++;
        @(negedge clk);
        checks++;
        if ({halted, issue_cnt} !== {1'b1, 8'd1})
            $display("FAIL stall_halt halted=%b cnt=%0d exp 1/1", halted, issue_cnt);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_addr [9] = '{8'h00, 8'h01, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h02, 8'h03};
        fill_halts();
        rom[8'h00] = 8'h40; rom[8'h01] = 8'hFE; rom[8'hFE] = 8'hC0; rom[8'hFF] = 8'h05;
        do_reset();
        op_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            checks++;
            if ({rom_addr, op_valid} !== {exp_addr[i], (i == 6) ? 1'b1 : 1'b0})
                $display("FAIL wrap_trace cyc=%0d addr=%h valid=%b exp addr=%h", i, rom_addr, op_valid, exp_addr[i]);
            else passed++;
            if (i == 6) begin
                checks++;
                if ({opcode, operand_a, operand_b} !== {3'd5, 8'h40, 8'hFE})
                    $display("FAIL wrap_payload got=%0d/%h/%h exp=5/40/fe", opcode, operand_a, operand_b);
                else passed++;
            end
            if (i < 8) @(negedge clk);
        end
        checks++;
        if ({halted, issue_cnt} !== {1'b1, 8'd1})
            $display("FAIL wrap_halt halted=%b cnt=%0d exp 1/1", halted, issue_cnt);
        else passed++;
    endtask

    task automatic test_reset_mid_issue();
        int n;
        fill_halts();
        rom[0] = 8'h01; rom[1] = 8'hAA; rom[2] = 8'hBB;
        rom[3] = 8'h02; rom[4] = 8'hCC; rom[5] = 8'hDD;
        do_reset();
        op_ready = 1'b1;
        pulse_start();
        n = 0;
        while (issue_cnt !== 8'd1 && n < 20) begin @(negedge clk); n++; end
        op_ready = 1'b0;
        n = 0;
        while (op_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if ({op_valid, issue_cnt} !== {1'b1, 8'd1})
            $display("FAIL mid_issue_setup valid=%b cnt=%0d exp 1/1", op_valid, issue_cnt);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({op_valid, busy, halted, rom_addr, issue_cnt, opcode, operand_a, operand_b} !== 37'd0)
            $display("FAIL mid_issue_reset valid=%b busy=%b addr=%h cnt=%0d op=%0d a=%h b=%h exp all 0",
                     op_valid, busy, rom_addr, issue_cnt, opcode, operand_a, operand_b);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_start_ignored_busy();
        fill_halts();
        rom[0] = 8'hC0; rom[1] = 8'hC8; rom[2] = 8'h40; rom[3] = 8'h00;
        do_reset();
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if ({busy, rom_addr} !== {1'b1, 8'(i % 4)})
                $display("FAIL busy_start cyc=%0d busy=%b addr=%h exp 1/%h", i, busy, rom_addr, 8'(i % 4));
            else passed++;
            start = (i >= 1 && i <= 6);
            @(negedge clk);
        end
        start = 1'b0;
        rom[0] = 8'h40; rom[1] = 8'h00;
        do_reset();
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({busy, halted, rom_addr} !== {1'b1, 1'b0, 8'(i % 2)})
                $display("FAIL self_jmp cyc=%0d busy=%b halted=%b addr=%h exp 1/0/%h",
                         i, busy, halted, rom_addr, 8'(i % 2));
            else passed++;
            start = (i == 4);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_random_programs();
        logic [18:0] exp_ops [$];
        logic [18:0] got_ops [$];
        logic [7:0]  pc, b, p1, p2;
        bit          done;
        int          steps, cyc;
        for (int t = 0; t < 20; t++) begin
            // Regenerate until the interpreter reaches a HALT within a bounded run.
            done = 1'b0;
            while (!done) begin
                for (int i = 0; i < 256; i++) begin
                    int r;
                    b = 8'($urandom);
                    r = int'($urandom_range(0, 99));
                    if (r < 25)      b[7:6] = 2'b00;
                    else if (r < 35) b[7:6] = 2'b01;
                    else if (r < 50) b[7:6] = 2'b10;
                    else             b[7:6] = 2'b11;
                    rom[i] = b;
                end
                exp_ops.delete();
                pc = 8'h00;
                steps = 0;
                while (!done && steps < 64) begin
                    b  = rom[pc];
                    p1 = pc + 8'd1;
                    p2 = pc + 8'd2;
                    case (b[7:6])
                        2'b00: begin exp_ops.push_back({b[2:0], rom[p1], rom[p2]}); pc = pc + 8'd3; end
                        2'b01: pc = rom[p1];
                        2'b10: begin pc = p1; done = 1'b1; end
                        default: pc = p1;
                    endcase
                    steps++;
                end
            end

            got_ops.delete();
            do_reset();
            pulse_start();
            cyc = 0;
            while (halted !== 1'b1 && cyc < 2000) begin
                op_ready = 1'($urandom_range(0, 1));
                if (op_valid && op_ready) got_ops.push_back({opcode, operand_a, operand_b});
                @(negedge clk);
                cyc++;
            end
            op_ready = 1'b0;

            checks++;
            if (halted !== 1'b1) $display("FAIL rand_timeout trial=%0d halted=%b exp 1", t, halted);
            else passed++;
            checks++;
            if (got_ops.size() != exp_ops.size())
                $display("FAIL rand_count trial=%0d got=%0d exp=%0d", t, got_ops.size(), exp_ops.size());
            else passed++;
            for (int k = 0; k < exp_ops.size() && k < got_ops.size(); k++) begin
                checks++;
                if (got_ops[k] !== exp_ops[k])
                    $display("FAIL rand_op trial=%0d idx=%0d got=%h exp=%h", t, k, got_ops[k], exp_ops[k]);
                else passed++;
            end
            checks++;
            if ({rom_addr, issue_cnt} !== {pc, 8'(exp_ops.size())})
                $display("FAIL rand_final trial=%0d addr=%h cnt=%0d exp addr=%h cnt=%0d",
                         t, rom_addr, issue_cnt, pc, 8'(exp_ops.size()));
            else passed++;
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        op_ready = 1'b0;
        fill_halts();
        test_reset();
        test_alu_latency();
        test_restart_after_halt();
        test_backpressure();
        test_wrap();
        test_reset_mid_issue();
        test_start_ignored_busy();
        test_random_programs();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
